prog_timer: RTL

Parametrised programmable down-counting timer, the successor to the fixed-period `timer2`, for game-tick, paddle-speed and ball-speed pacing in the Pong datapath. The period is loaded at run time rather than hard-coded. The timer supports auto-reload and one-shot modes, and an optional compile-time prescaler. It emits a one-cycle terminal-count pulse `Tc` and exposes live count and status to the controller FSM.

---
 rtl/prog_timer_pkg.sv | 17 +
 rtl/prog_timer_prescaler.sv | 52 +++++
 rtl/prog_timer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/prog_timer_pkg.sv
// prog_timer_pkg
//   Shared definitions for the programmable down-counting timer:
//   - state_e      : FSM state encoding (IDLE / RUN / DONE)
//   - MODE_RELOAD  : Mode value selecting auto-reload
//   - MODE_ONESHOT : Mode value selecting one-shot
package prog_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_RELOAD  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/prog_timer_prescaler.sv
// prog_timer_prescaler
//   Free-running tick divider. Produces Tick once every Div+1 enabled
//   cycles. The counter only advances while En is high, so dropping En
//   freezes the phase of the divider.
//
// Ports:
//   Clk  in   system clock
//   Rst  in   asynchronous active-low reset
//   En   in   count enable
//   Clr  in   synchronous clear of the divider phase (driven by Load)
//   Div  in   divider D; Tick every D+1 enabled cycles
//   Tick out  one-cycle tick, valid in the cycle the counter equals Div
module prog_timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  Clr,
  input  logic [PRESCALE_W-1:0] Div,
  output logic                  Tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;
  logic                  at_div;

  assign at_div = (cnt_q == Div);
  assign Tick   = En && at_div;

  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (En) begin
      if (at_div) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// prog_timer
//   Programmable down-counting timer with auto-reload and one-shot modes.
//   A Load captures the period P and mode and (re)starts the count; Tc
//   pulses once every P+1 ticks. All outputs come straight from flops.
//
//   Optional prescaler: define PROG_TIMER_PRESCALE_EN to divide the tick
//   rate by Prescale+1. Without the macro a tick is simply En, the
//   Prescale port is left unused and no prescaler flops exist.
//
// Ports:
//   Clk      in   system clock
//   Rst      in   asynchronous active-low reset
//   En       in   count enable; low freezes count, prescaler and state
//   Load     in   one-cycle strobe capturing LoadVal and Mode
//   LoadVal  in   period P
//   Mode     in   0 = auto-reload, 1 = one-shot (sampled on Load only)
//   Prescale in   divider D (only with PROG_TIMER_PRESCALE_EN)
//   Tc       out  registered terminal-count pulse
//   Count    out  current count
//   Busy     out  high while in RUN
//   Done     out  high while in DONE
//   DbgState out  current FSM state encoding (debug visibility)
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  Load,
  input  logic [WIDTH-1:0]      LoadVal,
  input  logic                  Mode,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  Tc,
  output logic [WIDTH-1:0]      Count,
  output logic                  Busy,
  output logic                  Done,
  output logic [1:0]            DbgState
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef PROG_TIMER_PRESCALE_EN
  prog_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .Clk  (Clk),
    .Rst  (Rst),
    .En   (En),
    .Clr  (Load),
    .Div  (Prescale),
    .Tick (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^Prescale;
  assign tick            = En;
`endif

  // Next-state logic. Load overrides everything, including a terminal
  // tick landing in the same cycle, so a reload never emits a stale Tc.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (Load) begin
      period_d = LoadVal;
      count_d  = LoadVal;
      mode_d   = Mode;
      state_d  = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              tc_d = 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                // Count stays at 0; only a new Load moves it.
                state_d = ST_DONE;
              end else begin
                count_d = period_q;
              end
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          // Ticks are ignored; everything holds until Load.
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= MODE_RELOAD;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Tc       = tc_q;
  assign Count    = count_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign DbgState = state_q;

endmodule
